// File: rtl/imuldiv_int_div_iterative_param_if.sv
// ---------------------------------------------------------------------------
// imuldiv_int_div_iterative_param_if
// Request/response bundle for the iterative integer divider.
//   divreq_msg_fn       : 0 = unsigned, 1 = signed
//   divreq_msg_a/_b     : dividend / divisor, W bits
//   divreq_val/_rdy     : request handshake
//   divresp_msg_result  : {remainder, quotient}, 2W bits
//   divresp_val/_rdy    : response handshake
// Modports: master = requester/consumer side, slave = divider side.
// ---------------------------------------------------------------------------
interface imuldiv_int_div_iterative_param_if #(
  parameter int W = 32
);
  logic           divreq_msg_fn;
  logic [W-1:0]   divreq_msg_a;
  logic [W-1:0]   divreq_msg_b;
  logic           divreq_val;
  logic           divreq_rdy;
  logic [2*W-1:0] divresp_msg_result;
  logic           divresp_val;
  logic           divresp_rdy;

  modport master (
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    input  divreq_rdy, divresp_msg_result, divresp_val
  );

  modport slave (
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    output divreq_rdy, divresp_msg_result, divresp_val
  );
endinterface

// File: rtl/imuldiv_int_div_iterative_param.sv
// ---------------------------------------------------------------------------
// imuldiv_int_div_iterative_param
// Restoring radix-2 divider, one quotient bit per clock, signed or unsigned.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any operation in flight
//   div   : slave side of imuldiv_int_div_iterative_param_if (same W)
// Parameters:
//   W         : operand width, 4..64
//   DIVZ_FAST : 1 = a zero divisor goes straight to DONE on accept
// Result is {remainder, quotient}; divide by zero gives quotient all ones and
// remainder = a. Signs are stripped on capture and restored on the output.
// ---------------------------------------------------------------------------
module imuldiv_int_div_iterative_param #(
  parameter int W         = 32,
  parameter int DIVZ_FAST = 1
) (
  input  logic clk,
  input  logic reset,
  imuldiv_int_div_iterative_param_if.slave div
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [2*W:0] rq_q, rq_d;     // {partial remainder (W+1), quotient (W)}
  logic [2*W:0] dvs_q, dvs_d;   // {1'b0, |b|, W zeros}
  logic [CW-1:0] cnt_q, cnt_d;
  logic         sign_a_q, sign_a_d;
  logic         sign_b_q, sign_b_d;
  logic         divz_q, divz_d;

  logic         accept;
  logic         a_neg, b_neg, b_zero, fast_divz;
  logic [W-1:0] a_mag, b_mag;
  logic [2*W:0] shifted, diff, step;
  logic [W-1:0] quot_raw, rem_raw, quot_fix, rem_fix;

  assign accept    = (state_q == IDLE) && div.divreq_val;
  assign a_neg     = div.divreq_msg_fn & div.divreq_msg_a[W-1];
  assign b_neg     = div.divreq_msg_fn & div.divreq_msg_b[W-1];
  assign a_mag     = a_neg ? -div.divreq_msg_a : div.divreq_msg_a;
  assign b_mag     = b_neg ? -div.divreq_msg_b : div.divreq_msg_b;
  assign b_zero    = (div.divreq_msg_b == '0);
  assign fast_divz = (DIVZ_FAST != 0) && b_zero;

  // One restoring step: a negative trial difference shows up in the top bit.
  assign shifted = rq_q << 1;
  assign diff    = shifted - dvs_q;
  assign step    = diff[2*W] ? shifted : (diff | {{(2*W){1'b0}}, 1'b1});

  // ---- state register ----
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- next-state logic ----
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = fast_divz ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (div.divresp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    div.divreq_rdy  = (state_q == IDLE);
    div.divresp_val = (state_q == DONE);
  end

  // ---- datapath next-state ----
  always_comb begin
    rq_d     = rq_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    divz_d   = divz_q;
    if (accept) begin
      // Fast zero-divide preloads what W iterations against zero would give.
      rq_d     = fast_divz ? {1'b0, a_mag, {W{1'b1}}} : {{(W+1){1'b0}}, a_mag};
      dvs_d    = {1'b0, b_mag, {W{1'b0}}};
      cnt_d    = CW'(W - 1);
      sign_a_d = a_neg;
      sign_b_d = b_neg;
      divz_d   = b_zero;
    end else if (state_q == CALC) begin
      rq_d  = step;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves
  // nothing behind and the cleared state is fully defined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_q     <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      rq_q     <= rq_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      divz_q   <= divz_d;
    end
  end

  // ---- output sign fix-up ----
  // Zero divide forces the quotient to all ones; the remainder already holds
  // |a| and the dividend sign fix-up restores the original a.
  assign quot_raw = rq_q[W-1:0];
  assign rem_raw  = rq_q[2*W-1:W];
  assign quot_fix = divz_q ? {W{1'b1}} :
                    ((sign_a_q ^ sign_b_q) ? -quot_raw : quot_raw);
  assign rem_fix  = sign_a_q ? -rem_raw : rem_raw;

  always_comb begin
    div.divresp_msg_result = (state_q == DONE) ? {rem_fix, quot_fix} : '0;
  end

endmodule

// File: tb/tb_imuldiv_int_div_iterative_param.sv
// ---------------------------------------------------------------------------
// tb_imuldiv_int_div_iterative_param
// Two W=32 dividers (DIVZ_FAST=1 and 0) driven with identical requests, plus a
// W=8 divider for the short-width and reset-abort sequences.
// ---------------------------------------------------------------------------
module tb_imuldiv_int_div_iterative_param;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  imuldiv_int_div_iterative_param_if #(.W(32)) if_f ();
  imuldiv_int_div_iterative_param_if #(.W(32)) if_s ();
  imuldiv_int_div_iterative_param_if #(.W(8))  if_8 ();

  imuldiv_int_div_iterative_param #(.W(32), .DIVZ_FAST(1)) dut_f (
    .clk(clk), .reset(reset), .div(if_f.slave));
  imuldiv_int_div_iterative_param #(.W(32), .DIVZ_FAST(0)) dut_s (
    .clk(clk), .reset(reset), .div(if_s.slave));
  imuldiv_int_div_iterative_param #(.W(8), .DIVZ_FAST(1)) dut_8 (
    .clk(clk), .reset(reset), .div(if_8.slave));

  // The slow-zero-divide instance mirrors every request of the fast one.
  assign if_s.divreq_msg_fn = if_f.divreq_msg_fn;
  assign if_s.divreq_msg_a  = if_f.divreq_msg_a;
  assign if_s.divreq_msg_b  = if_f.divreq_msg_b;
  assign if_s.divreq_val    = if_f.divreq_val;
  assign if_s.divresp_rdy   = if_f.divresp_rdy;

  typedef struct {
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat_f;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic accept32(input logic fn, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!(if_f.divreq_rdy && if_s.divreq_rdy) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) check("rdy32_timeout", 0, 1);
    if_f.divreq_msg_fn = fn;
    if_f.divreq_msg_a  = a;
    if_f.divreq_msg_b  = b;
    if_f.divreq_val    = 1'b1;
    @(posedge clk); #1;
    // Scramble request fields so the in-flight result must come from capture.
    if_f.divreq_val    = 1'b0;
    if_f.divreq_msg_fn = ~fn;
    if_f.divreq_msg_a  = ~a;
    if_f.divreq_msg_b  = a ^ b ^ 32'h5A5A_A5A5;
  endtask

  task automatic run32(input int idx, input vec_t v);
    logic seen_f = 1'b0, seen_s = 1'b0;
    int lat_f = -1, lat_s = -1;
    logic [63:0] res_f = '0, res_s = '0;
    accept32(v.fn, v.a, v.b);
    for (int c = 0; c <= 40 && !(seen_f && seen_s); c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (!seen_f && if_f.divresp_val) begin
        seen_f = 1'b1; lat_f = c; res_f = if_f.divresp_msg_result;
      end
      if (!seen_s && if_s.divresp_val) begin
        seen_s = 1'b1; lat_s = c; res_s = if_s.divresp_msg_result;
      end
    end
    check($sformatf("v%0d_lat_fast", idx), lat_f, v.lat_f);
    check($sformatf("v%0d_lat_slow", idx), lat_s, 32);
    check($sformatf("v%0d_res_fast", idx), res_f, {v.r, v.q});
    check($sformatf("v%0d_res_slow", idx), res_s, {v.r, v.q});
    @(posedge clk); #1;
    check($sformatf("v%0d_idle", idx),
          {if_f.divreq_rdy, if_s.divreq_rdy, if_f.divresp_val, if_s.divresp_val,
           if_f.divresp_msg_result == '0, if_s.divresp_msg_result == '0},
          6'b110011);
  endtask

  task automatic run8(input string name, input logic fn, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp, input int exp_lat);
    int guard = 0;
    int lat = -1;
    logic [15:0] res = '0;
    while (!if_8.divreq_rdy && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check({name, "_rdy_wait"}, guard, 0);
    if_8.divreq_msg_fn = fn;
    if_8.divreq_msg_a  = a;
    if_8.divreq_msg_b  = b;
    if_8.divreq_val    = 1'b1;
    @(posedge clk); #1;
    if_8.divreq_val    = 1'b0;
    if_8.divreq_msg_a  = ~a;
    if_8.divreq_msg_b  = ~b;
    for (int c = 0; c <= 20 && lat < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (if_8.divresp_val) begin lat = c; res = if_8.divresp_msg_result; end
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, res, exp);
    @(posedge clk); #1;
    check({name, "_idle"}, {if_8.divreq_rdy, if_8.divresp_val}, 2'b10);
  endtask

  initial begin
    int hold_ok;
    int vseen;
    int guard;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          32};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  32};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          32};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          0};
    vecs[4]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          32};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  32};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          32};
    vecs[7]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          32};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  0};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          32};
    vecs[10] = '{1'b0, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  32'h0000_0678,  32};

    if_f.divreq_msg_fn = 1'b0; if_f.divreq_msg_a = '0; if_f.divreq_msg_b = '0;
    if_f.divreq_val    = 1'b0; if_f.divresp_rdy  = 1'b1;
    if_8.divreq_msg_fn = 1'b0; if_8.divreq_msg_a = '0; if_8.divreq_msg_b = '0;
    if_8.divreq_val    = 1'b0; if_8.divresp_rdy  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", {if_f.divresp_val, if_s.divresp_val, if_8.divresp_val,
                       if_f.divresp_msg_result, if_8.divresp_msg_result}, '0);
    reset = 1'b0;
    check("rst_release", {if_f.divreq_rdy, if_s.divreq_rdy, if_8.divreq_rdy}, 3'b111);

    // Table-driven W=32 vectors, both zero-divide flavours
    for (int i = 0; i < 11; i++) run32(i, vecs[i]);

    // Response back-pressure: result must hold while divresp_rdy is low
    if_f.divresp_rdy = 1'b0;
    accept32(1'b0, 32'd100, 32'd7);
    guard = 0;
    while (!if_f.divresp_val && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    check("stall_lat", guard, 32);
    hold_ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (if_f.divresp_val && !if_f.divreq_rdy && if_s.divresp_val &&
          if_f.divresp_msg_result == {32'd2, 32'd14} &&
          if_s.divresp_msg_result == {32'd2, 32'd14})
        hold_ok++;
    end
    check("stall_hold_cycles", hold_ok, 10);
    if_f.divresp_rdy = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {if_f.divreq_rdy, if_f.divresp_val, if_s.divreq_rdy, if_s.divresp_val},
          4'b1010);

    // W=8 short-width operations
    run8("w8_ff_10",  1'b0, 8'hFF, 8'h10, 16'h0F0F, 8);
    run8("w8_ovf",    1'b1, 8'h80, 8'hFF, 16'h0080, 8);
    run8("w8_neg7_2", 1'b1, 8'hF9, 8'h02, 16'hFFFD, 8);

    // Reset during CALC aborts the operation
    if_8.divreq_msg_fn = 1'b0;
    if_8.divreq_msg_a  = 8'hFF;
    if_8.divreq_msg_b  = 8'h10;
    if_8.divreq_val    = 1'b1;
    @(posedge clk); #1;
    if_8.divreq_val    = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_clear", {if_8.divreq_rdy, if_8.divresp_val, if_8.divresp_msg_result},
          {1'b1, 1'b0, 16'h0});
    @(posedge clk); #1;
    reset = 1'b0;
    vseen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (if_8.divresp_val) vseen++;
    end
    check("abort_no_resp", vseen, 0);
    check("abort_rdy", if_8.divreq_rdy, 1'b1);

    // Request presented right at reset release is taken on the first edge
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run8("post_rst", 1'b0, 8'd100, 8'd7, 16'h020E, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imuldiv_int_div_iterative_param.md
IMULDIV_INT_DIV_ITERATIVE_PARAM -- requirements
Module: imuldiv_int_div_iterative_param

Interface
REQ-001 Parameter W, default 32, operand width in bits; SHALL support any W from 4 to 64.
REQ-002 Parameter DIVZ_FAST, default 1, when 1 a zero divisor bypasses iteration.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; SHALL clear all state immediately, independent of clk.
REQ-005 divreq_msg_fn  input  1  0 = unsigned, 1 = signed.
REQ-006 divreq_msg_a  input  W  dividend.
REQ-007 divreq_msg_b  input  W  divisor.
REQ-008 divreq_val  input  1  request valid.
REQ-009 divreq_rdy  output  1  block can accept a request.
REQ-010 divresp_msg_result  output  2W  {remainder[W-1:0], quotient[W-1:0]}.
REQ-011 divresp_val  output  1  response valid.
REQ-012 divresp_rdy  input  1  consumer accepts response.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; no other reachable state.
REQ-014 divreq_rdy SHALL be 1 only in IDLE; divresp_val SHALL be 1 only in DONE.
REQ-015 Request accepted on rising edge where IDLE and divreq_val=1; operands, fn and sign flags captured that edge.
REQ-016 Signed mode: operands converted to magnitudes (two's-complement negate if MSB=1) before capture; unsigned mode captures raw.
REQ-017 Remainder/quotient register SHALL be 2W+1 bits; divisor register holds {1'b0, |b|, W zeros}.
REQ-018 Each CALC cycle: shift left 1, subtract divisor; if result MSB=0 keep difference, quotient LSB=1; else keep shifted value, LSB=0 (restoring).
REQ-019 Iteration counter SHALL be clog2(W)+1 bits, loaded with W-1 on accept, decremented each CALC cycle; CALC->DONE on edge where counter=0.
REQ-020 Latency: accept at edge k, nonzero divisor -> divresp_val first high after edge k+W; exactly W CALC cycles.
REQ-021 DIVZ_FAST=1 and b=0: IDLE->DONE at accept edge; divresp_val high after edge k.
REQ-022 Divide by zero (either setting) SHALL yield quotient = all ones, remainder = a (original, sign preserved).
REQ-023 Signed quotient negated iff sign(a) XOR sign(b); signed remainder negated iff sign(a); fix-up combinational on output from stored flags.
REQ-024 Signed overflow (a = most negative, b = -1) SHALL yield quotient = most negative, remainder = 0.
REQ-025 divresp_msg_result SHALL hold stable while divresp_val=1 and divresp_rdy=0.
REQ-026 DONE->IDLE on edge with divresp_rdy=1; new request accepted no earlier than following edge (no overlap).
REQ-027 divreq_msg_* changes outside the accept edge SHALL not affect an in-flight result.
REQ-028 divresp_msg_result SHALL be 0 when not in DONE.

Reset
REQ-029 On reset assertion: state=IDLE, counter=0, all data/sign registers=0, divresp_val=0, divreq_rdy=1 after release.
REQ-030 Reset mid-CALC or mid-DONE SHALL abort the operation; no response for it is ever produced.
REQ-031 First request SHALL be accepted on first rising edge after reset deassertion with divreq_val=1.

Verification
REQ-032 W=32, unsigned a=100, b=7, resp_rdy=1 -> after 32 CALC cycles result {rem=2, quot=14}, then IDLE.
REQ-033 W=32, signed a=-7 (0xFFFFFFF9), b=2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1); a=0x80000000, b=0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-034 W=32, DIVZ_FAST=1, a=5, b=0 -> divresp_val one cycle after accept, result {0x00000005, 0xFFFFFFFF}; DIVZ_FAST=0 same result after 32 cycles.
REQ-035 Hold divresp_rdy=0 for 10 cycles in DONE -> divresp_val and result stable, divreq_rdy=0; release -> IDLE next edge.
REQ-036 W=8, unsigned a=0xFF, b=0x10 -> 8 CALC cycles, {rem=0x0F, quot=0x0F}; assert reset at CALC cycle 4 -> divresp_val never rises, divreq_rdy=1 after release.
